// File: rtl/serial_bit_feeder_pkg.sv
// Shared definitions for the serial bit feeder.
// The state encoding localparams are also used by the sequence detector's bench,
// so their values must stay fixed: ST_IDLE = 0, ST_SHIFT = 1.
package serial_bit_feeder_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT
    } state_t;

endpackage

// File: rtl/serial_bit_feeder_if.sv
// Load handshake and serial output bundle for serial_bit_feeder.
//
// Handshake (valid/ready): a word is transferred at a rising clk edge where
// load_valid && load_ready. While load_valid=1 and load_ready=0 the producer
// must hold load_data stable. load_valid may be dropped before acceptance;
// that withdraws the offer. load_ready never depends on load_valid.
//
// Signals:
//   load_data   producer -> feeder   WIDTH-bit word to serialize
//   load_valid  producer -> feeder   load_data is valid
//   load_ready  feeder -> producer   feeder accepts a word this cycle
//   serial_out  feeder -> consumer   serial bit stream (detector din)
//   bit_valid   feeder -> consumer   serial_out carries a data bit
//   frame_done  feeder -> consumer   pulse with the last bit of each word
//   state       feeder -> observer   current FSM state (debug visibility)
interface serial_bit_feeder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             bit_valid;
    logic             frame_done;
    logic             state;

    modport master (
        output load_data,
        output load_valid,
        input  load_ready,
        input  serial_out,
        input  bit_valid,
        input  frame_done,
        input  state
    );

    modport slave (
        input  load_data,
        input  load_valid,
        output load_ready,
        output serial_out,
        output bit_valid,
        output frame_done,
        output state
    );

endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder in front of the sequence detector.
// Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per
// clk. Back-to-back words stream without a gap so patterns spanning a word
// boundary remain visible to the detector.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    slave side of serial_bit_feeder_if (load handshake, serial_out,
//          bit_valid, frame_done, debug state)
//
// Parameters:
//   WIDTH      bits per word (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 first, 0: bit 0 first
//   IDLE_BIT   serial_out level when no word is being sent
module serial_bit_feeder
    import serial_bit_feeder_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    serial_bit_feeder_if.slave bus
);

    localparam int             CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  PRELAST = CW'(WIDTH - 2);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]      count_q, count_d;
    logic               serial_q, serial_d;
    logic               bit_valid_q, bit_valid_d;
    logic               frame_done_q, frame_done_d;

    logic               ready;
    logic               accept;
    logic               load_first;
    logic [WIDTH-1:0]   load_rest;
    logic               shift_first;
    logic [WIDTH-1:0]   shift_rest;

    // The bit on serial_out is already out of the shift register, so the
    // register only holds the bits still to come. On load the first bit goes
    // straight to serial_out and the remainder is stored pre-shifted.
    assign load_first  = MSB_FIRST ? bus.load_data[WIDTH-1] : bus.load_data[0];
    assign load_rest   = MSB_FIRST ? (bus.load_data << 1) : (bus.load_data >> 1);
    assign shift_first = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shift_rest  = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    // Ready while idle, or while the last bit of the current word is shown so
    // the next word can follow without a gap. Held low during reset.
    assign ready  = reset && ((state_q == S_IDLE) || (count_q == LAST));
    assign accept = bus.load_valid && ready;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        count_d      = count_q;
        serial_d     = serial_q;
        bit_valid_d  = bit_valid_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d     = S_SHIFT;
                    shreg_d     = load_rest;
                    count_d     = '0;
                    serial_d    = load_first;
                    bit_valid_d = 1'b1;
                end
            end
            S_SHIFT: begin
                if (count_q == LAST) begin
                    if (accept) begin
                        shreg_d     = load_rest;
                        count_d     = '0;
                        serial_d    = load_first;
                        bit_valid_d = 1'b1;
                    end else begin
                        state_d     = S_IDLE;
                        shreg_d     = '0;
                        count_d     = '0;
                        serial_d    = IDLE_BIT;
                        bit_valid_d = 1'b0;
                    end
                end else begin
                    shreg_d      = shift_rest;
                    count_d      = count_q + CW'(1);
                    serial_d     = shift_first;
                    // frame_done is registered, so raise it on the edge that
                    // brings the last bit onto serial_out.
                    frame_done_d = (count_q == PRELAST);
                end
            end
            default: begin
                state_d     = S_IDLE;
                serial_d    = IDLE_BIT;
                bit_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            count_q      <= '0;
            serial_q     <= IDLE_BIT;
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            count_q      <= count_d;
            serial_q     <= serial_d;
            bit_valid_q  <= bit_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.load_ready = ready;
    assign bus.serial_out = serial_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.state      = state_q;

endmodule
